keypad_code_ctrl: RTL and testbench
===================================

# keypad_code_ctrl

Keypad entry controller that sits in front of the security alarm FSM. It collects multi-digit PIN entries from a strobed keypad. It validates each entry against a loadable stored PIN and issues one-cycle arm/disarm command pulses toward the alarm FSM. It enforces an inter-digit timeout and a lockout after repeated bad codes.

## Interface
Parameters:
- PIN_DIGITS, 4, digits per PIN (1–8)
- DEFAULT_PIN, 16'h1234, stored PIN after reset; digit 0 is in the MS nibble
- DIGIT_TIMEOUT, 200, idle cycles allowed between keys before the entry is abandoned
- MAX_FAILS, 3, consecutive bad codes that trigger lockout
- LOCKOUT_CYCLES, 1000, length of the lockout period

Ports:
- sys_clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe marking key_code valid
- key_code  in  4  0x0–0x9 digit, 0xA ARM, 0xB DISARM, 0xF CLEAR, 0xC–0xE ignored
- pin_load  in  1  one-cycle request to replace the stored PIN
- pin_value  in  4*PIN_DIGITS  new PIN, sampled when pin_load is accepted
- arm_cmd  out  1  one-cycle pulse: valid PIN + ARM
- disarm_cmd  out  1  one-cycle pulse: valid PIN + DISARM
- bad_code  out  1  one-cycle pulse: rejected entry
- entry_active  out  1  high in COLLECT
- locked_out  out  1  high in LOCKOUT
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures

## Operation
- States: IDLE, COLLECT, CHECK, LOCKOUT. Reset enters IDLE. Reset clears the digit buffer, digit count, overflow flag, fail_count and timers, and reloads DEFAULT_PIN. Reset wins over every other input in any state.
- IDLE:
  - A digit key stores the digit, sets count=1 and enters COLLECT.
  - A command key, CLEAR or an ignored code is dropped.
  - pin_load is accepted only in IDLE, where it replaces the stored PIN. If pin_load and key_valid occur in the same cycle, pin_load wins and the key is dropped.
  - pin_load in any other state is ignored.
- COLLECT:
  - A digit with count<PIN_DIGITS is shifted in and increments count.
  - A digit with count==PIN_DIGITS sets overflow; count saturates and the buffer is unchanged.
  - ARM/DISARM latches the command and enters CHECK.
  - CLEAR returns to IDLE with no failure counted.
  - Timeout returns to IDLE with no failure counted and clears the buffer.
- CHECK lasts exactly one cycle. match = (count==PIN_DIGITS) & !overflow & (buffer==stored PIN).
  - On match: pulse arm_cmd or disarm_cmd per the latched command, clear fail_count, go to IDLE.
  - On mismatch: pulse bad_code and increment fail_count. Go to LOCKOUT if the new value equals MAX_FAILS, else IDLE.
- LOCKOUT: all keys and pin_load are ignored. After LOCKOUT_CYCLES cycles, clear fail_count and go to IDLE.
- Outputs are Moore, decoded from the registered state and registers:
  - arm_cmd, disarm_cmd and bad_code are high only during CHECK.
  - arm_cmd and disarm_cmd are never high together.
- Reset values: all outputs are 0.

## Timing
- A key strobe sampled at edge N takes effect at edge N. A command key at edge N puts the command pulse in cycle N..N+1, exactly one cycle wide.
- Timeout: if the last accepted key is at edge N and no further key arrives, state is IDLE after edge N+DIGIT_TIMEOUT. A key arriving at that same edge wins and restarts the timer. Any key strobe in COLLECT restarts the timer, including ignored codes.
- Lockout: entered at edge M, IDLE after edge M+LOCKOUT_CYCLES. locked_out is high for exactly LOCKOUT_CYCLES cycles.
- key_valid during CHECK is dropped.
- Back-to-back strobes every cycle are supported.
- Counter widths: timeout counter is $clog2(DIGIT_TIMEOUT+1) bits; lockout counter is $clog2(LOCKOUT_CYCLES+1) bits; neither wraps.

## Structure
- Shared package keypad_pkg holds:
  - the state_t enum (IDLE, COLLECT, CHECK, LOCKOUT)
  - key code constants KEY_ARM, KEY_DISARM, KEY_CLEAR
  - a function is_digit()
- One sub-module, cycle_timer, parameterised by LIMIT with inputs start/run and output done. It is instantiated twice: once for the digit timeout and once for the lockout.
- The FSM, digit buffer and stored-PIN register live in keypad_code_ctrl.

## Test plan
- Keys 1,2,3,4,A one per cycle → single arm_cmd pulse the cycle after A, fail_count=0. Then 1,2,3,4,B → single disarm_cmd pulse.
- Keys 1,2,3,A → bad_code pulse, fail_count=1. Then keys 1,2,3,4,5,A (overflow) → bad_code pulse, fail_count=2.
- Three consecutive bad entries → locked_out high for 1000 cycles. A valid 1,2,3,4,A during lockout gives no pulse. After lockout: fail_count=0, and 1,2,3,4,A gives arm_cmd.
- Keys 1,2, then 200 idle cycles → IDLE, entry_active low, fail_count unchanged. Key 3 at exactly cycle 200 → still in COLLECT.
- pin_load with 16'h9876 in IDLE → 1,2,3,4,A gives bad_code and 9,8,7,6,A gives arm_cmd. pin_load during COLLECT is ignored.
- reset asserted mid-entry after keys 1,2 and after two failures → all outputs 0, fail_count=0, PIN back to 16'h1234.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad entry controller.
//   state_t    - controller states
//   KEY_*      - command key codes on the keypad bus
//   is_digit() - true for key codes 0x0..0x9
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [3:0] KEY_ARM    = 4'hA;
  localparam logic [3:0] KEY_DISARM = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hF;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: elapsed-cycle timer used for the inter-digit timeout and the
// lockout period.
//   sys_clk - clock (rising edge)
//   reset   - synchronous active-high reset
//   start   - restart counting from zero at this edge (wins over done)
//   run     - count this cycle
//   done    - combinational; high on the cycle whose closing edge is the
//             LIMIT-th edge after the last start, while run is high
module cycle_timer #(
  parameter int unsigned LIMIT = 200
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic done
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] r_cnt;

  // Saturates at LIMIT so a stalled timer never wraps back into range.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != TOP)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign done = run && !start && (r_cnt == LAST);

endmodule

// File: rtl/keypad_code_ctrl.sv
// keypad_code_ctrl: collects PIN entries from a strobed keypad, validates
// them against a loadable stored PIN and emits one-cycle arm/disarm/bad
// pulses; enforces an inter-digit timeout and a lockout after MAX_FAILS
// consecutive bad codes.
//   sys_clk, reset        - clock, synchronous active-high reset
//   key_valid, key_code   - keypad strobe and code (0-9, A arm, B disarm, F clear)
//   pin_load, pin_value   - stored-PIN replacement (accepted in IDLE only)
//   arm_cmd, disarm_cmd   - one-cycle command pulses on a matching entry
//   bad_code              - one-cycle pulse on a rejected entry
//   entry_active          - entry in progress
//   locked_out            - lockout period active
//   fail_count            - consecutive failures
module keypad_code_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned              PIN_DIGITS     = 4,
  parameter logic [4*PIN_DIGITS-1:0]  DEFAULT_PIN    = 16'h1234,
  parameter int unsigned              DIGIT_TIMEOUT  = 200,
  parameter int unsigned              MAX_FAILS      = 3,
  parameter int unsigned              LOCKOUT_CYCLES = 1000
) (
  input  logic                             sys_clk,
  input  logic                             reset,
  input  logic                             key_valid,
  input  logic [3:0]                       key_code,
  input  logic                             pin_load,
  input  logic [4*PIN_DIGITS-1:0]          pin_value,
  output logic                             arm_cmd,
  output logic                             disarm_cmd,
  output logic                             bad_code,
  output logic                             entry_active,
  output logic                             locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int unsigned BW = 4 * PIN_DIGITS;
  localparam int unsigned CW = $clog2(PIN_DIGITS + 1);
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam logic [CW-1:0] FULL     = CW'(PIN_DIGITS);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_buf;
  logic [BW-1:0]   r_pin;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic            r_cmd_arm;
  logic [FW-1:0]   r_fail;

  logic            w_digit;
  logic            w_match;
  logic [FW-1:0]   w_fail_inc;
  logic            w_to_start, w_to_done;
  logic            w_lk_start, w_lk_done;

  assign w_digit    = key_valid && is_digit(key_code);
  assign w_match    = (r_count == FULL) && !r_ovf && (r_buf == r_pin);
  assign w_fail_inc = r_fail + 1'b1;

  // Any strobe inside an entry restarts the idle window, ignored codes included.
  assign w_to_start = key_valid &&
                      (((r_state == IDLE) && !pin_load && w_digit) ||
                       (r_state == COLLECT));
  assign w_lk_start = (r_state == CHECK) && !w_match && (w_fail_inc == FAIL_MAX);

  cycle_timer #(.LIMIT(DIGIT_TIMEOUT)) u_digit_timer (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (w_to_start),
    .run     (r_state == COLLECT),
    .done    (w_to_done)
  );

  cycle_timer #(.LIMIT(LOCKOUT_CYCLES)) u_lockout_timer (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (w_lk_start),
    .run     (r_state == LOCKOUT),
    .done    (w_lk_done)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    arm_cmd      = 1'b0;
    disarm_cmd   = 1'b0;
    bad_code     = 1'b0;
    entry_active = 1'b0;
    locked_out   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!pin_load && w_digit) w_state_nxt = COLLECT;
      end
      COLLECT: begin
        entry_active = 1'b1;
        if (key_valid) begin
          if ((key_code == KEY_ARM) || (key_code == KEY_DISARM)) w_state_nxt = CHECK;
          else if (key_code == KEY_CLEAR)                        w_state_nxt = IDLE;
        end else if (w_to_done) begin
          w_state_nxt = IDLE;
        end
      end
      CHECK: begin
        arm_cmd    = w_match && r_cmd_arm;
        disarm_cmd = w_match && !r_cmd_arm;
        bad_code   = !w_match;
        w_state_nxt = w_lk_start ? LOCKOUT : IDLE;
      end
      LOCKOUT: begin
        locked_out = 1'b1;
        if (w_lk_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_buf     <= '0;
      r_pin     <= DEFAULT_PIN;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_cmd_arm <= 1'b0;
      r_fail    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (pin_load) begin
            r_pin <= pin_value;
          end else if (w_digit) begin
            r_buf   <= BW'(key_code);
            r_count <= CW'(1);
            r_ovf   <= 1'b0;
          end
        end
        COLLECT: begin
          if (key_valid) begin
            if (is_digit(key_code)) begin
              if (r_count < FULL) begin
                r_buf   <= (r_buf << 4) | BW'(key_code);
                r_count <= r_count + 1'b1;
              end else begin
                r_ovf <= 1'b1;
              end
            end else if ((key_code == KEY_ARM) || (key_code == KEY_DISARM)) begin
              r_cmd_arm <= (key_code == KEY_ARM);
            end else if (key_code == KEY_CLEAR) begin
              r_buf   <= '0;
              r_count <= '0;
              r_ovf   <= 1'b0;
            end
          end else if (w_to_done) begin
            r_buf   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        end
        CHECK: begin
          r_fail <= w_match ? '0 : w_fail_inc;
        end
        LOCKOUT: begin
          if (w_lk_done) r_fail <= '0;
        end
        default: ;
      endcase
    end
  end

  assign fail_count = r_fail;

endmodule

// File: tb/tb_keypad_code_ctrl.sv
// tb_keypad_code_ctrl: directed test-plan sequences followed by randomized
// keypad traffic, all compared cycle by cycle against a behavioural model
// that tracks the entry as a queue of typed digits.
module tb_keypad_code_ctrl;

  localparam int TO = 200;
  localparam int LK = 1000;
  localparam int MF = 3;
  localparam logic [3:0] KA = 4'hA;
  localparam logic [3:0] KB = 4'hB;
  localparam logic [3:0] KF = 4'hF;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        pin_load = 1'b0;
  logic [15:0] pin_value = '0;
  logic        arm_cmd, disarm_cmd, bad_code, entry_active, locked_out;
  logic [1:0]  fail_count;

  keypad_code_ctrl #(
    .PIN_DIGITS     (4),
    .DEFAULT_PIN    (16'h1234),
    .DIGIT_TIMEOUT  (200),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (1000)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .pin_load     (pin_load),
    .pin_value    (pin_value),
    .arm_cmd      (arm_cmd),
    .disarm_cmd   (disarm_cmd),
    .bad_code     (bad_code),
    .entry_active (entry_active),
    .locked_out   (locked_out),
    .fail_count   (fail_count)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail = 0;
  int arm_seen = 0, disarm_seen = 0, bad_seen = 0, lock_seen = 0;
  logic [1:0] last_fail;
  logic       last_entry;

  // Reference model: digits typed so far, entry flag, idle cycles since
  // the last key, pending verdict (1 arm, 2 disarm, 3 bad), fails, lockout
  // cycles remaining, stored PIN.
  int          q[$];
  bit          m_entry = 0;
  int          m_idle = 0;
  int          m_res = 0;
  int          m_fails = 0;
  int          m_lock = 0;
  logic [15:0] m_pin = 16'h1234;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_match();
    if (q.size() != 4) return 0;
    for (int i = 0; i < 4; i++)
      if (q[i] != int'(m_pin[15-4*i -: 4])) return 0;
    return 1;
  endfunction

  task automatic model_step(input logic kv, input logic [3:0] kc, input logic pl,
                            input logic [15:0] pv, input logic rst);
    if (rst) begin
      q.delete(); m_entry = 0; m_idle = 0; m_res = 0;
      m_fails = 0; m_lock = 0; m_pin = 16'h1234;
    end else if (m_res != 0) begin
      if (m_res == 3) begin
        m_fails++;
        if (m_fails == MF) m_lock = LK;
      end else begin
        m_fails = 0;
      end
      m_res = 0;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_entry) begin
      if (kv) begin
        m_idle = 0;
        if (kc <= 4'd9) q.push_back(int'(kc));
        else if (kc == KA || kc == KB) begin
          m_res = m_match() ? ((kc == KA) ? 1 : 2) : 3;
          m_entry = 0;
        end else if (kc == KF) m_entry = 0;
      end else begin
        m_idle++;
        if (m_idle == TO) m_entry = 0;
      end
    end else begin
      if (pl) m_pin = pv;
      else if (kv && kc <= 4'd9) begin
        q.delete(); q.push_back(int'(kc)); m_entry = 1; m_idle = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("arm_cmd",      32'(arm_cmd),      32'(m_res == 1));
    check_eq("disarm_cmd",   32'(disarm_cmd),   32'(m_res == 2));
    check_eq("bad_code",     32'(bad_code),     32'(m_res == 3));
    check_eq("entry_active", 32'(entry_active), 32'(m_entry));
    check_eq("locked_out",   32'(locked_out),   32'(m_lock > 0));
    check_eq("fail_count",   32'(fail_count),   32'(m_fails));
    if (arm_cmd === 1'b1)    arm_seen++;
    if (disarm_cmd === 1'b1) disarm_seen++;
    if (bad_code === 1'b1)   bad_seen++;
    if (locked_out === 1'b1) lock_seen++;
    last_fail  = fail_count;
    last_entry = entry_active;
  endtask

  task automatic cyc(input logic kv, input logic [3:0] kc, input logic pl,
                     input logic [15:0] pv, input logic rst);
    @(negedge sys_clk);
    compare_outputs();
    key_valid = kv; key_code = kc; pin_load = pl; pin_value = pv; reset = rst;
    @(posedge sys_clk);
    model_step(kv, kc, pl, pv, rst);
  endtask

  task automatic key(input logic [3:0] k);
    cyc(1'b1, k, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic press_pin(input logic [31:0] code, input int nd);
    logic [31:0] c;
    c = code;
    for (int i = 0; i < nd; i++) key(c[4*(nd-1-i) +: 4]);
  endtask

  int a0, d0, b0, l0;
  int cur;
  logic [15:0] rpv;

  initial begin
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    idle(2);

    // Good code, arm then disarm
    a0 = arm_seen; d0 = disarm_seen;
    press_pin(32'h1234, 4); key(KA); idle(2);
    check_eq("arm_once", 32'(arm_seen - a0), 32'd1);
    press_pin(32'h1234, 4); key(KB); idle(2);
    check_eq("disarm_once", 32'(disarm_seen - d0), 32'd1);

    // Short entry, then overflow entry
    b0 = bad_seen;
    press_pin(32'h123, 3); key(KA); idle(2);
    check_eq("fails_one", 32'(last_fail), 32'd1);
    press_pin(32'h12345, 5); key(KA); idle(2);
    check_eq("fails_two", 32'(last_fail), 32'd2);
    check_eq("bad_twice", 32'(bad_seen - b0), 32'd2);

    // Third bad code locks out; valid code inside lockout is ignored
    l0 = lock_seen;
    press_pin(32'h9999, 4); key(KA); idle(1);
    a0 = arm_seen;
    press_pin(32'h1234, 4); key(KA);
    idle(LK + 20);
    check_eq("lock_len", 32'(lock_seen - l0), 32'(LK));
    check_eq("lock_no_arm", 32'(arm_seen - a0), 32'd0);
    check_eq("lock_fail_clr", 32'(last_fail), 32'd0);
    a0 = arm_seen;
    press_pin(32'h1234, 4); key(KA); idle(2);
    check_eq("arm_after_lock", 32'(arm_seen - a0), 32'd1);

    // Timeout abandons entry; key exactly at the limit keeps it alive
    press_pin(32'h123, 3); key(KA); idle(1);
    press_pin(32'h12, 2); idle(TO + 1);
    check_eq("timeout_idle", 32'(last_entry), 32'd0);
    check_eq("timeout_fails", 32'(last_fail), 32'd1);
    press_pin(32'h12, 2); idle(TO - 1); key(4'h3); idle(1);
    check_eq("timeout_edge", 32'(last_entry), 32'd1);
    a0 = arm_seen;
    key(4'h4); key(KA); idle(2);
    check_eq("arm_after_edge", 32'(arm_seen - a0), 32'd1);

    // PIN reload in IDLE; reload during entry ignored; load beats key
    cyc(1'b1, 4'h1, 1'b1, 16'h9876, 1'b0);
    idle(1);
    b0 = bad_seen; a0 = arm_seen;
    press_pin(32'h1234, 4); key(KA); idle(1);
    press_pin(32'h9876, 4); key(KA); idle(1);
    key(4'h9); cyc(1'b0, '0, 1'b1, 16'h1111, 1'b0);
    press_pin(32'h876, 3); key(KA); idle(2);
    check_eq("reload_bad", 32'(bad_seen - b0), 32'd1);
    check_eq("reload_arm", 32'(arm_seen - a0), 32'd2);

    // Reset mid-entry after two failures
    press_pin(32'h1, 1); key(KA); idle(1);
    press_pin(32'h2, 1); key(KA); idle(1);
    press_pin(32'h12, 2);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    idle(2);
    check_eq("reset_fails", 32'(last_fail), 32'd0);
    a0 = arm_seen;
    press_pin(32'h1234, 4); key(KA); idle(2);
    check_eq("reset_pin", 32'(arm_seen - a0), 32'd1);

    // Randomized traffic
    cur = 0;
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 100) begin
        if (cur < 4) begin
          key(4'((m_pin >> (4 * (3 - cur))) & 16'hF));
          cur++;
        end else begin
          key(($urandom % 2) ? KA : KB);
          cur = 0;
        end
      end else if (r < 140) begin
        key(4'($urandom_range(0, 15)));
      end else if (r < 185) begin
        idle(1);
      end else if (r < 189) begin
        idle($urandom_range(195, 205));
      end else if (r < 196) begin
        rpv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        cyc($urandom_range(0, 1) == 1, 4'($urandom_range(0, 9)), 1'b1, rpv, 1'b0);
      end else if (r < 198) begin
        key(KF);
      end else begin
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        cur = 0;
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
